stream_mux_rr: RTL and testbench

// - N-input, DATA_W-wide valid/ready stream multiplexer with round-robin arbitration.
// - Registered single-beat output stage; sustains 1 beat/cycle.
// - Sequential successor to our combinational multiplexer: select is generated internally.
// - Sits between parallel producer channels and one shared downstream consumer.

---
 rtl/stream_mux_rr.sv | 127 ++++++++++++
 tb/tb_stream_mux_rr.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_IN-channel valid/ready stream mux with round-robin
// arbitration and a registered single-beat output stage (1 beat/cycle).
// Optional packet lock: define STREAM_MUX_PKT_LOCK_EN to keep the grant on
// one channel from its first beat until its in_last beat.
module stream_mux_rr #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 4,
  parameter int SEL_W  = ($clog2(N_IN) <= 0) ? 1 : $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data [N_IN-1:0],
  input  logic [N_IN-1:0]   in_valid,
  input  logic [N_IN-1:0]   in_last,
  output logic [N_IN-1:0]   in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_IN - 1);
  localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N_IN);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] s_grant, grant;
  logic             s_hit, hit;
  logic [SEL_W:0]   cand;
  logic             load, xfer, commit;

  // Output register is empty or is being drained this cycle.
  assign load = !out_valid || out_ready;
  assign xfer = load && hit;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    s_grant = rr_ptr;
    s_hit   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!s_hit && in_valid[cand[SEL_W-1:0]]) begin
        s_hit   = 1'b1;
        s_grant = cand[SEL_W-1:0];
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state, state_d;
  logic [SEL_W-1:0] lock_ch, lock_d;

  // While locked, the packet owner keeps the grant even when it idles.
  always_comb begin
    grant = s_grant;
    hit   = s_hit;
    if (state == LOCKED) begin
      grant = lock_ch;
      hit   = in_valid[lock_ch];
    end
  end

  // Only the last beat of a packet advances the round-robin pointer.
  assign commit = xfer && in_last[grant];

  // Lock state register; a reset drops any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_d;
      lock_ch <= lock_d;
    end
  end

  // Lock on a non-last first beat, unlock on the last beat.
  always_comb begin
    state_d = state;
    lock_d  = lock_ch;
    case (state)
      IDLE: if (xfer && !in_last[grant]) begin
        state_d = LOCKED;
        lock_d  = grant;
      end
      LOCKED: if (xfer && in_last[grant]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`else
  assign grant  = s_grant;
  assign hit    = s_hit;
  assign commit = xfer;
`endif

  // Per-channel accept: only the grant winner, never during reset.
  for (genvar i = 0; i < N_IN; i++) begin : g_rdy
    assign in_ready[i] = rst_n && load && hit && (grant == SEL_W'(i));
  end

  // Advance the pointer past the committing channel, explicit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (commit) rr_ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
  end

  // Output stage: load the winner's beat, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[grant];
        out_last <= in_last[grant];
        out_sel  <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: table of per-cycle vectors with hand-derived
// in_ready grants, a queue scoreboard for output beats, plus hand-written
// reset, backpressure, packet-lock and N_IN=3 wrap sequences.
module tb_stream_mux_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data [3:0];
  logic [3:0] in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_last, out_valid, out_ready;
  logic [1:0] out_sel;

  logic [7:0] in_data3 [2:0];
  logic [2:0] v3, l3, rdy3;
  logic [7:0] od3;
  logic       ol3, ov3, or3;
  logic [1:0] os3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic [7:0] d; logic l; logic [1:0] s;} beat_t;
  beat_t q[$];

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [7:0] base;
    logic [3:0] rdy;
  } vec_t;
  vec_t tbl [14];

  stream_mux_rr #(.DATA_W(8), .N_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.DATA_W(8), .N_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(v3),
    .in_last(l3), .in_ready(rdy3), .out_data(od3), .out_last(ol3),
    .out_sel(os3), .out_valid(ov3), .out_ready(or3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check before posedge, update scoreboard.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                      input logic [7:0] base, input logic [3:0] rdy, input string nm);
    beat_t b;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    for (int i = 0; i < 4; i++) in_data[i] = base + 8'(i * 16);
    #2;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0 && out_valid) begin
      chk({nm, ".out_data"}, 32'(out_data), 32'(q[0].d));
      chk({nm, ".out_last"}, 32'(out_last), 32'(q[0].l));
      chk({nm, ".out_sel"},  32'(out_sel),  32'(q[0].s));
    end
    @(posedge clk);
    if (ordy && q.size() != 0) void'(q.pop_front());
    for (int i = 0; i < 4; i++)
      if (v[i] && rdy[i]) begin
        b.d = base + 8'(i * 16);
        b.l = l[i];
        b.s = 2'(i);
        q.push_back(b);
      end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".out_data"},  32'(out_data),  32'd0);
    chk({nm, ".out_last"},  32'(out_last),  32'd0);
    chk({nm, ".out_sel"},   32'(out_sel),   32'd0);
    chk({nm, ".in_ready"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    // rr_ptr trace in comments: value before -> after each vector.
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 8'h01, 4'b0001}; // 0->1
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 8'h02, 4'b0010}; // 1->2
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 8'h03, 4'b0100}; // 2->3
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 8'h04, 4'b1000}; // 3->0
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 8'h05, 4'b0001}; // 0->1
    tbl[5]  = '{4'b0000, 4'b1111, 1'b1, 8'h06, 4'b0000}; // 1
    tbl[6]  = '{4'b1001, 4'b1111, 1'b1, 8'h07, 4'b1000}; // 1->0
    tbl[7]  = '{4'b0110, 4'b1111, 1'b1, 8'h08, 4'b0010}; // 0->2
    tbl[8]  = '{4'b0010, 4'b1111, 1'b1, 8'h09, 4'b0010}; // 2->2 wrap
    tbl[9]  = '{4'b1000, 4'b1111, 1'b1, 8'h0a, 4'b1000}; // 2->0
    tbl[10] = '{4'b1000, 4'b1111, 1'b1, 8'h0b, 4'b1000}; // 0->0
    tbl[11] = '{4'b0100, 4'b1111, 1'b1, 8'h0c, 4'b0100}; // 0->3
    tbl[12] = '{4'b0100, 4'b1111, 1'b1, 8'h85, 4'b0100}; // 3->3, ch2 data 0xA5
    tbl[13] = '{4'b0000, 4'b1111, 1'b1, 8'h0d, 4'b0000}; // drain

    rst_n = 1'b0;
    in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 8'hff;
    v3 = '0; l3 = '1; or3 = 1'b1;
    for (int i = 0; i < 3; i++) in_data3[i] = 8'h00;
    #3;
    chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 14; k++)
      step(tbl[k].v, tbl[k].l, tbl[k].ordy, tbl[k].base, tbl[k].rdy, $sformatf("vec%0d", k));

    // Backpressure: beat held for 3 cycles, then next beat accepted same cycle.
    step(4'b0011, 4'b1111, 1'b1, 8'h20, 4'b0001, "bp_load");
    step(4'b0011, 4'b1111, 1'b0, 8'h21, 4'b0000, "bp_hold0");
    step(4'b0011, 4'b1111, 1'b0, 8'h22, 4'b0000, "bp_hold1");
    step(4'b0011, 4'b1111, 1'b0, 8'h23, 4'b0000, "bp_hold2");
    step(4'b0011, 4'b1111, 1'b1, 8'h24, 4'b0010, "bp_release");
    step(4'b0000, 4'b1111, 1'b1, 8'h25, 4'b0000, "bp_drain");
    step(4'b0001, 4'b1111, 1'b1, 8'h26, 4'b0001, "ptr_to1");

    // ch1 sends a 3-beat packet while ch0 stays valid.
`ifdef STREAM_MUX_PKT_LOCK_EN
    step(4'b0011, 4'b1101, 1'b1, 8'h30, 4'b0010, "lock_b0");
    step(4'b0001, 4'b1101, 1'b1, 8'h31, 4'b0000, "lock_idle");
    step(4'b0011, 4'b1101, 1'b1, 8'h32, 4'b0010, "lock_b1");
    step(4'b0011, 4'b1111, 1'b1, 8'h33, 4'b0010, "lock_b2");
    step(4'b0011, 4'b1111, 1'b1, 8'h34, 4'b0001, "lock_ch0");
`else
    step(4'b0011, 4'b1101, 1'b1, 8'h30, 4'b0010, "rr_b0");
    step(4'b0011, 4'b1101, 1'b1, 8'h31, 4'b0001, "rr_ch0a");
    step(4'b0011, 4'b1101, 1'b1, 8'h32, 4'b0010, "rr_b1");
    step(4'b0011, 4'b1111, 1'b1, 8'h33, 4'b0001, "rr_ch0b");
`endif
    step(4'b0000, 4'b1111, 1'b1, 8'h35, 4'b0000, "pkt_drain");

    // Reset with a beat held in the output register.
    step(4'b0010, 4'b1111, 1'b1, 8'h40, 4'b0010, "pre_rst");
    in_valid = 4'b1111; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 4'b1111, 1'b1, 8'h50, 4'b0100, "post_rst");
    step(4'b0000, 4'b1111, 1'b1, 8'h51, 4'b0000, "post_rst_out");

    // N_IN=3: ch2 wins, pointer wraps 2 -> 0, then ch0 wins over ch1.
    in_data3[0] = 8'h11; in_data3[1] = 8'h22; in_data3[2] = 8'h33;
    v3 = 3'b100;
    #2;
    chk("n3.rdy_ch2", 32'(rdy3), 32'b100);
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b011;
    #2;
    chk("n3.rdy_ch0", 32'(rdy3), 32'b001);
    chk("n3.valid0",  32'(ov3),  32'd1);
    chk("n3.sel0",    32'(os3),  32'd2);
    chk("n3.data0",   32'(od3),  32'h33);
    @(posedge clk);
    @(negedge clk);
    v3 = 3'b000;
    #2;
    chk("n3.valid1",  32'(ov3),  32'd1);
    chk("n3.sel1",    32'(os3),  32'd0);
    chk("n3.data1",   32'(od3),  32'h11);
    chk("n3.last1",   32'(ol3),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
